// File: rtl/dds_dac_spi.sv
// Serialises one DDS sample per frame, MSB first, to a serial DAC over SPI mode 0.
// Optional build macro DAC_OFFSET_BIN_EN: invert the sample MSB at accept (two's-complement -> offset-binary).
module dds_dac_spi #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [DATA_WIDTH-1:0]   din_code;

    function automatic logic [DATA_WIDTH-1:0] to_dac_code(input logic signed [DATA_WIDTH-1:0] s);
`ifdef DAC_OFFSET_BIN_EN
        return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
`else
        return s;
`endif
    endfunction

    assign din_code  = to_dac_code(din);
    assign din_ready = en && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        shreg   <= din_code;
                        mosi    <= din_code[DATA_WIDTH-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling toggle: the DAC has sampled the current bit on the preceding rise.
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state      <= GAP;
                                cs_n       <= 1'b1;
                                mosi       <= 1'b0;
                                frame_done <= 1'b1;
                                bit_cnt    <= '0;
                                gap_cnt    <= '0;
                                shreg      <= '0;
                            end else begin
                                shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                                mosi    <= shreg[DATA_WIDTH-2];
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            sclk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_dac_spi.sv
// Scoreboard bench for dds_dac_spi: a handshake model queues expected words, a monitor reassembles frames.
module tb_dds_dac_spi;

    localparam int DW        = 32;
    localparam int CD        = 2;
    localparam int CG        = 2;
    localparam int FRAME_CYC = 2 * CD * DW;
    localparam int BUSY_CYC  = FRAME_CYC + CG;

`ifdef DAC_OFFSET_BIN_EN
    localparam logic [31:0] EXP_A5 = 32'h25A5_0F0F;
    localparam logic [31:0] EXP_01 = 32'h8000_0001;
    localparam logic [31:0] EXP_0F = 32'h8F1E_2D3C;
`else
    localparam logic [31:0] EXP_A5 = 32'hA5A5_0F0F;
    localparam logic [31:0] EXP_01 = 32'h0000_0001;
    localparam logic [31:0] EXP_0F = 32'h0F1E_2D3C;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din       = '0;
    logic          din_ready, sclk, cs_n, mosi, busy, frame_done;

    always #5 clk = ~clk;

    dds_dac_spi #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(CG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .busy(busy), .frame_done(frame_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    function automatic logic [31:0] wire_fmt(input logic [31:0] d);
`ifdef DAC_OFFSET_BIN_EN
        return d ^ 32'h8000_0000;
`else
        return d;
`endif
    endfunction

    // Reference handshake model: idle for accept, then busy for a full frame plus the gap.
    logic [31:0] exp_q[$];
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            exp_q.delete();
        end else if (m_cnt == 0) begin
            if (en && din_valid) begin
                exp_q.push_back(wire_fmt(din));
                m_cnt = BUSY_CYC;
            end
        end else begin
            m_cnt--;
        end
    end

    // Monitor: sample mosi on each sclk rise, close the frame on frame_done.
    logic        prev_sclk = 1'b0;
    logic [31:0] word      = '0;
    logic [31:0] last_word = '0;
    int          bits      = 0;
    int          cs_low    = 0;
    int          n_done    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0;
            word      = '0;
            bits      = 0;
            cs_low    = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                word = {word[30:0], mosi};
                bits++;
            end
            prev_sclk = sclk;
            if (!cs_n) cs_low++;
            if (frame_done) begin
                chk("frame_bits", 32'(bits), 32'(DW));
                chk("cs_low_cycles", 32'(cs_low), 32'(FRAME_CYC));
                chk("frame_done_cs_n", 32'(cs_n), 32'd1);
                if (exp_q.size() == 0) chk("sb_unexpected_frame", 32'd0, 32'd1);
                else chk("frame_word", word, exp_q.pop_front());
                last_word = word;
                n_done++;
                word   = '0;
                bits   = 0;
                cs_low = 0;
            end
            chk("din_ready", 32'(din_ready), 32'(en && (m_cnt == 0)));
        end
    end

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int k = 0;
        while (n_done < target && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_bits(input int nb, input string nm);
        int k = 0;
        while (bits < nb && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(bits >= nb), 32'd1);
    endtask

    initial begin
        int d0;
        int k;

        // Power-on reset window
        rst_n = 1'b0;
        #12;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        #18;
        rst_n = 1'b1;
        #1;
        chk("ready_en0", 32'(din_ready), 32'd0);
        en = 1'b1;
        #1;
        chk("ready_en1", 32'(din_ready), 32'd1);

        // Single frame
        d0 = n_done;
        send(32'hA5A5_0F0F);
        wait_done(d0 + 1, "single_timeout");
        chk("single_word", last_word, EXP_A5);
        repeat (150) @(negedge clk);
        #1;
        chk("single_pulse_count", 32'(n_done - d0), 32'd1);

        // Continuous DDS-style stream
        d0 = n_done;
        @(negedge clk);
        din       = 32'h1000_0000;
        din_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            din = din + 32'd1;
        end
        din_valid = 1'b0;
        wait_done(d0 + 4, "stream_timeout");
        repeat (10) @(negedge clk);
        #1;
        chk("stream_frames", 32'(n_done - d0), 32'd4);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Enable dropped mid-frame
        d0 = n_done;
        @(negedge clk);
        din       = 32'hC3C3_1234;
        din_valid = 1'b1;
        wait_bits(10, "en_drop_bits_timeout");
        en = 1'b0;
        wait_done(d0 + 1, "en_drop_timeout");
        chk("en_drop_word", last_word, wire_fmt(32'hC3C3_1234));
        chk("en_drop_busy_gap", 32'(busy), 32'd1);
        k = 0;
        while (busy && k < 3) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("en_drop_busy_fall", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("en_drop_ready", 32'(din_ready), 32'd0);
        chk("en_drop_no_frame", 32'(n_done - d0), 32'd1);
        din_valid = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Reset in the middle of a frame
        d0 = n_done;
        send(32'hDEAD_BEEF);
        wait_bits(12, "mid_rst_bits_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(sclk), 32'd0);
        chk("mid_rst_mosi", 32'(mosi), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(din_ready), 32'd1);
        chk("mid_rst_no_frame", 32'(n_done - d0), 32'd0);
        send(32'h0F1E_2D3C);
        wait_done(d0 + 1, "post_rst_timeout");
        chk("post_rst_word", last_word, EXP_0F);
        repeat (10) @(negedge clk);

        // Offset-binary conversion check
        d0 = n_done;
        send(32'h0000_0001);
        wait_done(d0 + 1, "macro_timeout");
        chk("macro_word", last_word, EXP_01);
        repeat (10) @(negedge clk);
        #1;
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
